// File: rtl/ula_arbitro_if.sv
// Requester / ULA bus of ula_arbitro.
// The arbiter takes the slave modport. The requesters and the ULA instance sit on the master side.
interface ula_arbitro_if #(
  parameter int W = 32
);
  // requester 0
  logic         req_0;
  logic [4:0]   op_0;
  logic [W-1:0] rs_0;
  logic [W-1:0] rt_0;
  logic         ack_0;
  logic         done_0;
  logic         erro_0;
  // requester 1
  logic         req_1;
  logic [4:0]   op_1;
  logic [W-1:0] rs_1;
  logic [W-1:0] rt_1;
  logic         ack_1;
  logic         done_1;
  logic         erro_1;
  // shared results
  logic [W-1:0] resultado;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  // ULA side
  logic [4:0]   ula_op;
  logic [W-1:0] ula_rs;
  logic [W-1:0] ula_rt;
  logic [W-1:0] ula_saida;
  logic [W-1:0] ula_hi;
  logic [W-1:0] ula_lo;

  modport slave (
    input  req_0, op_0, rs_0, rt_0, req_1, op_1, rs_1, rt_1,
    input  ula_saida, ula_hi, ula_lo,
    output ack_0, done_0, erro_0, ack_1, done_1, erro_1,
    output resultado, hi, lo, ula_op, ula_rs, ula_rt
  );

  modport master (
    output req_0, op_0, rs_0, rt_0, req_1, op_1, rs_1, rt_1,
    output ula_saida, ula_hi, ula_lo,
    input  ack_0, done_0, erro_0, ack_1, done_1, erro_1,
    input  resultado, hi, lo, ula_op, ula_rs, ula_rt
  );
endinterface

// File: rtl/ula_arbitro.sv
// ula_arbitro: round-robin arbiter that shares one ULA between two requesters.
// Requester 0 is the core datapath. Requester 1 is the OS/IO context.
// Each operation runs through the sequence IDLE -> EXEC -> WAIT -> DONE.
// Only one op is in flight at a time, so throughput is one op every 4 cycles.
// Optional feature: define ULA_ARB_DIV0_TRAP_EN to trap division or remainder by zero.
// A trapped op is never issued to the ULA, it returns resultado=0, and erro pulses together with done.
module ula_arbitro #(
  parameter int         W       = 32,
  parameter logic [4:0] IDLE_OP = 5'b11111
) (
  input logic        clock,
  input logic        reset,
  ula_arbitro_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, WAIT, DONE} state_t;

  localparam logic [4:0] OP_MULT = 5'b00010;

  state_t       state, state_nxt;
  logic         owner;
  logic         last_grant;
  logic         trap;
  logic         grant_any;
  logic         winner;
  logic [4:0]   sel_op;
  logic [W-1:0] sel_rs;
  logic [W-1:0] sel_rt;
  logic [4:0]   op_q;
  logic [W-1:0] rs_q;
  logic [W-1:0] rt_q;
  logic [W-1:0] resultado_q;
  logic [W-1:0] hi_q;
  logic [W-1:0] lo_q;

  // Round-robin choice: on a tie the requester that did not win last time wins now.
  always_comb begin
    grant_any = bus.req_0 | bus.req_1;
    winner    = (bus.req_0 && bus.req_1) ? ~last_grant : bus.req_1;
    sel_op    = winner ? bus.op_1 : bus.op_0;
    sel_rs    = winner ? bus.rs_1 : bus.rs_0;
    sel_rt    = winner ? bus.rt_1 : bus.rt_0;
  end

  // Next-state logic: only the IDLE state waits. All other states advance every cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = EXEC;
      EXEC:    state_nxt = WAIT;
      WAIT:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Latch the granted request. Capture the ULA result at the end of WAIT.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      op_q        <= IDLE_OP;
      rs_q        <= '0;
      rt_q        <= '0;
      resultado_q <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      if (state == IDLE && grant_any) begin
        owner      <= winner;
        last_grant <= winner;
        op_q       <= sel_op;
        rs_q       <= sel_rs;
        rt_q       <= sel_rt;
      end
      if (state == WAIT) begin
        resultado_q <= trap ? '0 : bus.ula_saida;
        if (!trap && op_q == OP_MULT) begin
          hi_q <= bus.ula_hi;
          lo_q <= bus.ula_lo;
        end
      end
    end
  end

`ifdef ULA_ARB_DIV0_TRAP_EN
  // Flag a granted div/rem whose divisor is zero. The flag suppresses issue and raises erro.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) trap <= 1'b0;
    else if (state == IDLE && grant_any)
      trap <= ((sel_op == 5'b00011) || (sel_op == 5'b00100)) && (sel_rt == '0);
  end
`else
  // No trap: every op is issued to the ULA as-is.
  always_comb trap = 1'b0;
`endif

  // Handshake pulses and ULA drive. Outside EXEC the ULA sees the idle op with zero operands.
  always_comb begin
    bus.ack_0  = 1'b0;
    bus.ack_1  = 1'b0;
    bus.done_0 = 1'b0;
    bus.done_1 = 1'b0;
    bus.erro_0 = 1'b0;
    bus.erro_1 = 1'b0;
    bus.ula_op = IDLE_OP;
    bus.ula_rs = '0;
    bus.ula_rt = '0;
    case (state)
      EXEC: begin
        bus.ack_0 = ~owner;
        bus.ack_1 = owner;
        if (!trap) begin
          bus.ula_op = op_q;
          bus.ula_rs = rs_q;
          bus.ula_rt = rt_q;
        end
      end
      DONE: begin
        bus.done_0 = ~owner;
        bus.done_1 = owner;
        bus.erro_0 = trap & ~owner;
        bus.erro_1 = trap & owner;
      end
      default: ;
    endcase
  end

  assign bus.resultado = resultado_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

endmodule

// File: tb/tb_ula_arbitro.sv
// Testbench for ula_arbitro.
// A registered stand-in models the ULA.
// A timeline model derives the expected handshake and results from the grant cycle and operand arithmetic.
// The model is compared with the DUT on every falling edge. Directed tests pin the model with literals.
module tb_ula_arbitro;
  localparam int         W       = 32;
  localparam logic [4:0] IDLE_OP = 5'b11111;

  logic clock = 1'b0;
  logic reset = 1'b1;

  ula_arbitro_if #(.W(W)) bus ();

  ula_arbitro #(.W(W), .IDLE_OP(IDLE_OP)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ULA stand-in: result registered on the rising edge; unknown/idle ops hold the output.
  function automatic logic [W-1:0] alu_out(input logic [4:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [W-1:0] hold);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (op)
      5'b00000: return a + b;
      5'b00001: return a - b;
      5'b00010: return p[W-1:0];
      5'b00011: return (b == '0) ? '1 : a / b;
      5'b00100: return (b == '0) ? a : a % b;
      default:  return hold;
    endcase
  endfunction

  always @(posedge clock) begin
    bus.ula_saida <= alu_out(bus.ula_op, bus.ula_rs, bus.ula_rt, bus.ula_saida);
    if (bus.ula_op == 5'b00010) {bus.ula_hi, bus.ula_lo} <= 64'(bus.ula_rs) * 64'(bus.ula_rt);
  end

  // ---------------- timeline model ----------------
  // m_g is the edge count at which the current op was granted. The ack cycle follows edge m_g.
  // The done cycle follows edge m_g+2. The next grant can happen at edge m_g+4 or later.
  int           cyc     = 0;
  int           m_g     = -100;
  logic         m_owner = 1'b0;
  logic         m_last  = 1'b1;
  logic         m_trap  = 1'b0;
  logic [4:0]   m_op    = IDLE_OP;
  logic [W-1:0] m_rs    = '0;
  logic [W-1:0] m_rt    = '0;
  logic [W-1:0] m_res   = '0;
  logic [W-1:0] m_hi    = '0;
  logic [W-1:0] m_lo    = '0;

  initial begin
    logic w;
    logic [63:0] prod;
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        m_g = -100; m_owner = 1'b0; m_last = 1'b1; m_trap = 1'b0;
        m_res = '0; m_hi = '0; m_lo = '0;
      end else begin
        cyc++;
        if (cyc == m_g + 2) begin
          if (m_trap) m_res = '0;
          else begin
            case (m_op)
              5'b00000: m_res = m_rs + m_rt;
              5'b00001: m_res = m_rs - m_rt;
              5'b00010: begin
                prod = 64'(m_rs) * 64'(m_rt);
                m_hi = prod[63:32]; m_lo = prod[31:0]; m_res = prod[31:0];
              end
              5'b00011: m_res = (m_rt == '0) ? '1 : m_rs / m_rt;
              5'b00100: m_res = (m_rt == '0) ? m_rs : m_rs % m_rt;
              default:  m_res = m_res;
            endcase
          end
        end
        if (cyc >= m_g + 4 && (bus.req_0 || bus.req_1)) begin
          w = (bus.req_0 && bus.req_1) ? ~m_last : bus.req_1;
          m_last = w; m_owner = w; m_g = cyc;
          m_op = w ? bus.op_1 : bus.op_0;
          m_rs = w ? bus.rs_1 : bus.rs_0;
          m_rt = w ? bus.rt_1 : bus.rt_0;
`ifdef ULA_ARB_DIV0_TRAP_EN
          m_trap = ((m_op == 5'b00011) || (m_op == 5'b00100)) && (m_rt == '0);
`else
          m_trap = 1'b0;
`endif
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    logic ex, dn;
    forever begin
      @(negedge clock);
      ex = (cyc == m_g);
      dn = (cyc == m_g + 2);
      check("ack_0",  bus.ack_0,  ex && !m_owner);
      check("ack_1",  bus.ack_1,  ex && m_owner);
      check("done_0", bus.done_0, dn && !m_owner);
      check("done_1", bus.done_1, dn && m_owner);
      check("erro_0", bus.erro_0, dn && !m_owner && m_trap);
      check("erro_1", bus.erro_1, dn && m_owner && m_trap);
      check("ula_op", bus.ula_op, (ex && !m_trap) ? m_op : IDLE_OP);
      check("ula_rs", bus.ula_rs, (ex && !m_trap) ? m_rs : '0);
      check("ula_rt", bus.ula_rt, (ex && !m_trap) ? m_rt : '0);
      check("resultado", bus.resultado, m_res);
      check("hi", bus.hi, m_hi);
      check("lo", bus.lo, m_lo);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic raise(input int who, input logic [4:0] op, input logic [W-1:0] rs,
                       input logic [W-1:0] rt);
    if (who == 0) begin
      bus.req_0 = 1'b1; bus.op_0 = op; bus.rs_0 = rs; bus.rt_0 = rt;
    end else begin
      bus.req_1 = 1'b1; bus.op_1 = op; bus.rs_1 = rs; bus.rt_1 = rt;
    end
  endtask

  task automatic wait_ack(input int who, input bit drop, output int at);
    at = -1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock); #1;
      if (bus.ack_0 || bus.ack_1) begin
        check("ack_owner", bus.ack_1, 64'(who));
        at = cyc;
        if (drop) begin
          if (bus.ack_0) bus.req_0 = 1'b0;
          if (bus.ack_1) bus.req_1 = 1'b0;
        end
        return;
      end
    end
    checks++; errors++;
    $display("FAIL ack_timeout actual=none required=ack_%0d", who);
  endtask

  task automatic wait_done(input int who, output int at);
    at = -1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock); #1;
      if (bus.done_0 || bus.done_1) begin
        check("done_owner", bus.done_1, 64'(who));
        at = cyc;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL done_timeout actual=none required=done_%0d", who);
  endtask

  task automatic pulse_reset();
    @(negedge clock); #1 reset = 1'b0;
    @(negedge clock); #1 reset = 1'b1;
  endtask

  initial begin
    int r, a, d, a2, d1, d2, nd;
    bus.req_0 = 1'b0; bus.op_0 = '0; bus.rs_0 = '0; bus.rt_0 = '0;
    bus.req_1 = 1'b0; bus.op_1 = '0; bus.rs_1 = '0; bus.rt_1 = '0;
    #2 reset = 1'b0;
    repeat (2) @(negedge clock);
    #1 reset = 1'b1;

    // 1: reset values, then a single add
    check("rst_ula_op", bus.ula_op, 5'b11111);
    check("rst_resultado", bus.resultado, 0);
    check("rst_ack_0", bus.ack_0, 0);
    @(negedge clock); r = cyc; raise(0, 5'b00000, 5, 7);
    wait_ack(0, 1, a);
    check("t1_ack_latency", a - r, 1);
    wait_done(0, d);
    check("t1_done_latency", d - a, 2);
    check("t1_res", bus.resultado, 12);
    @(negedge clock); check("t1_ula_op_after", bus.ula_op, 5'b11111);

    // 2: tie after reset -> 0 first, then 1, next tie -> 0 again
    pulse_reset();
    @(negedge clock);
    raise(0, 5'b00001, 10, 3);
    raise(1, 5'b00001, 9, 4);
    wait_ack(0, 1, a); wait_done(0, d); check("t2_res0", bus.resultado, 7);
    wait_ack(1, 1, a); wait_done(1, d); check("t2_res1", bus.resultado, 5);
    @(negedge clock);
    raise(0, 5'b00000, 1, 1);
    raise(1, 5'b00000, 2, 2);
    wait_ack(0, 1, a); wait_done(0, d); check("t2_tie2_res0", bus.resultado, 2);
    wait_ack(1, 1, a); wait_done(1, d); check("t2_tie2_res1", bus.resultado, 4);

    // 3: multiply sets HI/LO, a following add leaves them alone
    @(negedge clock); raise(1, 5'b00010, 32'h0001_0000, 32'h0001_0000);
    wait_ack(1, 1, a); wait_done(1, d);
    check("t3_hi", bus.hi, 1);
    check("t3_lo", bus.lo, 0);
    check("t3_res", bus.resultado, 0);
    @(negedge clock); raise(0, 5'b00000, 2, 3);
    wait_ack(0, 1, a); wait_done(0, d);
    check("t3_add_res", bus.resultado, 5);
    check("t3_hi_kept", bus.hi, 1);

    // 4: divide by zero, then a normal divide
    @(negedge clock); raise(0, 5'b00011, 9, 0);
    wait_ack(0, 1, a); wait_done(0, d);
`ifdef ULA_ARB_DIV0_TRAP_EN
    check("t4_erro", bus.erro_0, 1);
    check("t4_res", bus.resultado, 0);
`else
    check("t4_erro", bus.erro_0, 0);
    check("t4_res", bus.resultado, 32'hFFFF_FFFF);
`endif
    @(negedge clock); raise(0, 5'b00011, 20, 3);
    wait_ack(0, 1, a); wait_done(0, d);
    check("t4_div_res", bus.resultado, 6);
    check("t4_div_erro", bus.erro_0, 0);

    // 5: reset during WAIT aborts the op
    @(negedge clock); raise(0, 5'b00000, 1, 2);
    wait_ack(0, 1, a);
    @(posedge clock); #2 reset = 1'b0;
    #1;
    check("t5_ula_op", bus.ula_op, 5'b11111);
    check("t5_res", bus.resultado, 0);
    check("t5_hi", bus.hi, 0);
    check("t5_done", bus.done_0, 0);
    repeat (3) @(negedge clock);
    #1 reset = 1'b1;
    @(negedge clock); raise(0, 5'b00000, 1, 2);
    wait_ack(0, 1, a); wait_done(0, d);
    check("t5_after_res", bus.resultado, 3);

    // 6: req_0 held 6 cycles past ack -> two ops, done 4 cycles apart
    @(negedge clock); raise(0, 5'b00000, 4, 4);
    wait_ack(0, 0, a);
    nd = 0; d1 = -1; d2 = -1; a2 = -1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock); #1;
      if (bus.done_0) begin
        nd++;
        if (nd == 1) d1 = cyc; else d2 = cyc;
      end
      if (bus.ack_0) a2 = cyc;
      if (i == 5) bus.req_0 = 1'b0;
    end
    check("t6_ndone", nd, 2);
    check("t6_done_gap", d2 - d1, 4);
    check("t6_ack2", a2 - a, 4);
    check("t6_res", bus.resultado, 8);

    repeat (3) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
